countdown_timer: RTL and testbench
==================================

# countdown_timer

Downstream stage of the keypad encoder in the appliance timer path. Consumes the encoder's BCD digit `D`, its active-low key-valid strobe `loadn` and its `pgt_1Hz` tick. Typed digits shift into a four-digit MM:SS BCD register. While counting is enabled, the register decrements once per second and stops at 00:00. Outputs drive the display decoder and the control FSM (`zero`, `done`).

## Interface

Parameters:
- `DIGIT_W`, 4: width of one BCD digit.
- `SEC_TENS_MAX`, 5: reload value of the seconds-tens digit on borrow.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `D`  in  4  BCD digit from the encoder; valid while `loadn`=0.
- `loadn`  in  1  key-valid strobe, active low; stays low while the key is held.
- `pgt_1Hz`  in  1  1 Hz tick level, sampled on `clk`.
- `clr`  in  1  synchronous clear of the time register, active high.
- `enable`  in  1  1 = count down; 0 = idle/entry mode.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  BCD time digits.
- `zero`  out  1  1 when all four digits are 0.
- `done`  out  1  one-cycle pulse when a countdown reaches 00:00.

## Operation

- Edge detection: registered `loadn_q` (reset 1) and `tick_q` (reset 0).
  - `key_ev` = `loadn_q` & ~`loadn`.
  - `tick_ev` = ~`tick_q` & `pgt_1Hz`.
- Priority per cycle: `rst` > `clr` > load > count.
- Reset: all digits 0, `done`=0, `loadn_q`=1, `tick_q`=0. This makes `zero`=1.
- `clr`: all digits 0, `done`=0. Edge registers still update.
- Load happens when `enable`=0, `key_ev`=1 and `D`≤9.
  - Shift left one digit: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`D`.
  - The old `min_tens` is discarded.
  - If `D`>9, no shift occurs.
  - A held key produces exactly one load.
  - `key_ev` while `enable`=1 is ignored.
- Count happens when `enable`=1, `tick_ev`=1 and `zero`=0. The register decrements as a BCD ripple-borrow chain:
  - `sec_ones`: 0→9 with borrow, else −1.
  - `sec_tens`: on borrow, 0→`SEC_TENS_MAX` with borrow, else −1.
  - `min_ones`: on borrow, 0→9 with borrow, else −1.
  - `min_tens`: on borrow, −1. It is never 0 with borrow pending, because `zero`=0.
- Loaded `sec_tens` values 6–9 are kept verbatim and decrement normally; no normalisation.
- `tick_ev` with `zero`=1 or `enable`=0: no change.
- `done`=1 for exactly the cycle after the decrement that produces 00:00. Otherwise `done`=0.
- `zero` is combinational from the digit registers.

## Timing

- Load latency: `loadn` first sampled low at edge k (with `loadn_q`=1) → new digits visible after edge k. `D` is sampled at that same edge.
- Tick latency: `pgt_1Hz` first sampled high at edge k → decremented value visible after edge k. At most one decrement per `pgt_1Hz` rising edge, regardless of its high time.
- `done` is asserted after the same edge that makes `zero`=1, and deasserts after the next edge.
- `rst` or `clr` asserted mid-count: digits are 0 after that edge. No `done` pulse is generated.
- Simultaneous `key_ev` and `tick_ev` with `enable`=0: load only. With `enable`=1: count only.
- `enable` dropping mid-count freezes the digits. Raising it again resumes from the held value.

## Structure

- Shared package/header holds:
  - `DIGIT_W`.
  - BCD constants `BCD_MAX`=9 and `SEC_TENS_MAX`=5.
  - Localparams for the load and count priority encoding.
- One sub-module, `bcd_down_digit`:
  - Parameter: reload value.
  - Inputs: `clk`, `rst`, `clr`, `load`, `load_val`, `dec`.
  - Outputs: `q`, `borrow_out`.
  - `countdown_timer` instantiates it four times (reload 9, `SEC_TENS_MAX`, 9, 9) and owns the edge detectors and `done`.

## Test plan

- Reset, then idle → all digits 0, `zero`=1, `done`=0.
- Key entry with `enable`=0: press D=1, 2, 3, 0, each as a `loadn` low held for 5 cycles → display 12:30, one shift per press.
- Keypad edge cases:
  - Press D=12 → no change.
  - Five presses 1..5 → 23:45 (first digit discarded).
- Countdown with `enable`=1 from 01:00, one tick → 00:59. From 10:00, one tick → 09:59.
- Countdown to zero from 00:02:
  - Two ticks → 00:00 and `zero`=1, with a single-cycle `done` after the second tick.
  - A third tick → no change and no `done`.
- Simultaneous and mid-operation events:
  - `key_ev` during `enable`=1 is ignored.
  - `clr` mid-count at 05:17 → 00:00 on the next edge, with no `done`.
  - `rst` during a held key → no load after release and re-press until a new falling edge.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared constants and the per-cycle operation encoding for the MM:SS countdown timer.
package countdown_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  // One operation wins per cycle; reset is handled separately inside each digit.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } op_e;

  function automatic op_e sel_op(input logic clr, input logic load, input logic count);
    if (clr)        return OP_CLR;
    else if (load)  return OP_LOAD;
    else if (count) return OP_COUNT;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the time register: clear, parallel load, or decrement with wrap to RELOAD.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter int                W      = 4,
  parameter logic [W-1:0]      RELOAD = 4'd9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         borrow_out
);

  logic [W-1:0] r_q;
  logic         w_is_zero;

  assign w_is_zero  = (r_q == '0);
  assign borrow_out = dec & w_is_zero;
  assign q          = r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (dec) begin
      r_q <= w_is_zero ? RELOAD : (r_q - W'(1));
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Keypad-loaded MM:SS BCD countdown register, decremented once per 1 Hz tick edge.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int                    DIGIT_W      = countdown_timer_pkg::DIGIT_W,
  parameter logic [DIGIT_W-1:0]    SEC_TENS_MAX = countdown_timer_pkg::SEC_TENS_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] D,
  input  logic               loadn,
  input  logic               pgt_1Hz,
  input  logic               clr,
  input  logic               enable,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               zero,
  output logic               done
);

  localparam logic [DIGIT_W-1:0] W_NINE = DIGIT_W'(9);

  logic r_loadn_q;
  logic r_tick_q;
  logic r_done;

  logic w_key_ev;
  logic w_tick_ev;
  logic w_load;
  logic w_count;
  logic w_at_one;
  op_e  w_op;
  logic w_clr_op;
  logic w_load_op;
  logic w_count_op;
  logic w_b0;
  logic w_b1;
  logic w_b2;
  logic w_b3;

  assign w_key_ev  = r_loadn_q & ~loadn;
  assign w_tick_ev = ~r_tick_q & pgt_1Hz;

  // Enable splits the two modes, so load and count can never both fire.
  assign w_load  = ~enable & w_key_ev & (D <= W_NINE);
  assign w_count = enable & w_tick_ev & ~zero;

  assign w_op       = sel_op(clr, w_load, w_count);
  assign w_clr_op   = (w_op == OP_CLR);
  assign w_load_op  = (w_op == OP_LOAD);
  assign w_count_op = (w_op == OP_COUNT);

  assign zero     = (sec_ones == '0) && (sec_tens == '0) && (min_ones == '0) && (min_tens == '0);
  assign w_at_one = (sec_ones == DIGIT_W'(1)) && (sec_tens == '0) && (min_ones == '0) && (min_tens == '0);
  assign done     = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loadn_q <= 1'b1;
      r_tick_q  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_loadn_q <= loadn;
      r_tick_q  <= pgt_1Hz;
      // Only the decrement out of 00:01 lands on 00:00.
      r_done    <= w_count_op & w_at_one;
    end
  end

  bcd_down_digit #(.W(DIGIT_W), .RELOAD(W_NINE)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(w_clr_op), .load(w_load_op), .load_val(D),
    .dec(w_count_op), .q(sec_ones), .borrow_out(w_b0)
  );

  bcd_down_digit #(.W(DIGIT_W), .RELOAD(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(w_clr_op), .load(w_load_op), .load_val(sec_ones),
    .dec(w_b0), .q(sec_tens), .borrow_out(w_b1)
  );

  bcd_down_digit #(.W(DIGIT_W), .RELOAD(W_NINE)) u_min_ones (
    .clk(clk), .rst(rst), .clr(w_clr_op), .load(w_load_op), .load_val(sec_tens),
    .dec(w_b1), .q(min_ones), .borrow_out(w_b2)
  );

  bcd_down_digit #(.W(DIGIT_W), .RELOAD(W_NINE)) u_min_tens (
    .clk(clk), .rst(rst), .clr(w_clr_op), .load(w_load_op), .load_val(min_ones),
    .dec(w_b2), .q(min_tens), .borrow_out(w_b3)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer with an expected-value queue and hand sequences.
module tb_countdown_timer;

  localparam int W = 19;  // {time[15:0], zero, done_count[1:0]}

  localparam int K_RST   = 0;
  localparam int K_PRESS = 1;
  localparam int K_TICK  = 2;
  localparam int K_EN    = 3;
  localparam int K_CLR   = 4;

  typedef struct {
    int          kind;
    logic [3:0]  d;
    logic [15:0] exp_time;
    logic        exp_zero;
    logic [1:0]  exp_done;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       clr;
  logic       enable;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       zero;
  logic       done;

  vec_t           vecs[64];
  int             n_vecs;
  logic [W-1:0]   exp_q[$];
  int             checks;
  int             errors;
  int             done_cnt;

  countdown_timer dut (
    .clk(clk), .rst(rst), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz), .clr(clr),
    .enable(enable), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .zero(zero), .done(done)
  );

  // Clock and done-pulse monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    loadn = 1'b0;
    D     = d;
    cyc(5);
    loadn = 1'b1;
    cyc(2);
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1;
    cyc(3);
    pgt_1Hz = 1'b0;
    cyc(2);
  endtask

  task automatic add(input int kind, input logic [3:0] d, input logic [15:0] t,
                     input logic z, input logic [1:0] dn);
    vecs[n_vecs].kind     = kind;
    vecs[n_vecs].d        = d;
    vecs[n_vecs].exp_time = t;
    vecs[n_vecs].exp_zero = z;
    vecs[n_vecs].exp_done = dn;
    n_vecs++;
  endtask

  task automatic apply(input int kind, input logic [3:0] d);
    case (kind)
      K_RST:   begin rst = 1'b1; cyc(2); rst = 1'b0; cyc(1); end
      K_PRESS: press(d);
      K_TICK:  tick();
      K_EN:    begin enable = d[0]; cyc(1); end
      default: begin clr = 1'b1; cyc(1); clr = 1'b0; cyc(1); end
    endcase
  endtask

  // Scoreboard: pop the oldest expectation and compare against the DUT outputs.
  task automatic check(input string name);
    logic [W-1:0] e;
    logic [15:0]  act_t;
    logic [1:0]   act_d;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: expectation queue empty", name);
      return;
    end
    e     = exp_q.pop_front();
    act_t = {min_tens, min_ones, sec_tens, sec_ones};
    act_d = (done_cnt > 3) ? 2'd3 : 2'(done_cnt);
    checks++;
    if (act_t !== e[18:3]) begin
      errors++;
      $display("FAIL %s time: got %h want %h", name, act_t, e[18:3]);
    end
    checks++;
    if (zero !== e[2]) begin
      errors++;
      $display("FAIL %s zero: got %b want %b", name, zero, e[2]);
    end
    checks++;
    if (act_d !== e[1:0]) begin
      errors++;
      $display("FAIL %s done cycles: got %0d want %0d", name, act_d, e[1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; D = '0; loadn = 1'b1; pgt_1Hz = 1'b0; clr = 1'b0; enable = 1'b0;
    checks = 0; errors = 0; done_cnt = 0; n_vecs = 0;

    // Entry, rejected digit, and overflow of the leading digit
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 1, 16'h0001, 0, 0);
    add(K_PRESS, 2, 16'h0012, 0, 0);
    add(K_PRESS, 3, 16'h0123, 0, 0);
    add(K_PRESS, 0, 16'h1230, 0, 0);
    add(K_PRESS, 12, 16'h1230, 0, 0);
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 1, 16'h0001, 0, 0);
    add(K_PRESS, 2, 16'h0012, 0, 0);
    add(K_PRESS, 3, 16'h0123, 0, 0);
    add(K_PRESS, 4, 16'h1234, 0, 0);
    add(K_PRESS, 5, 16'h2345, 0, 0);
    // Borrow across minutes
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 1, 16'h0001, 0, 0);
    add(K_PRESS, 0, 16'h0010, 0, 0);
    add(K_PRESS, 0, 16'h0100, 0, 0);
    add(K_EN,    1, 16'h0100, 0, 0);
    add(K_TICK,  0, 16'h0059, 0, 0);
    add(K_EN,    0, 16'h0059, 0, 0);
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 1, 16'h0001, 0, 0);
    add(K_PRESS, 0, 16'h0010, 0, 0);
    add(K_PRESS, 0, 16'h0100, 0, 0);
    add(K_PRESS, 0, 16'h1000, 0, 0);
    add(K_EN,    1, 16'h1000, 0, 0);
    add(K_TICK,  0, 16'h0959, 0, 0);
    add(K_PRESS, 7, 16'h0959, 0, 0);
    // Run to zero; a further tick does nothing
    add(K_EN,    0, 16'h0959, 0, 0);
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 2, 16'h0002, 0, 0);
    add(K_EN,    1, 16'h0002, 0, 0);
    add(K_TICK,  0, 16'h0001, 0, 0);
    add(K_TICK,  0, 16'h0000, 1, 1);
    add(K_TICK,  0, 16'h0000, 1, 0);
    // Loaded seconds-tens above 5 decrements as-is
    add(K_EN,    0, 16'h0000, 1, 0);
    add(K_PRESS, 8, 16'h0008, 0, 0);
    add(K_PRESS, 0, 16'h0080, 0, 0);
    add(K_EN,    1, 16'h0080, 0, 0);
    add(K_TICK,  0, 16'h0079, 0, 0);
    // Freeze/resume and clear mid-count
    add(K_EN,    0, 16'h0079, 0, 0);
    add(K_RST,   0, 16'h0000, 1, 0);
    add(K_PRESS, 5, 16'h0005, 0, 0);
    add(K_PRESS, 1, 16'h0051, 0, 0);
    add(K_PRESS, 7, 16'h0517, 0, 0);
    add(K_EN,    1, 16'h0517, 0, 0);
    add(K_TICK,  0, 16'h0516, 0, 0);
    add(K_EN,    0, 16'h0516, 0, 0);
    add(K_TICK,  0, 16'h0516, 0, 0);
    add(K_EN,    1, 16'h0516, 0, 0);
    add(K_TICK,  0, 16'h0515, 0, 0);
    add(K_CLR,   0, 16'h0000, 1, 0);
    add(K_EN,    0, 16'h0000, 1, 0);

    for (int i = 0; i < n_vecs; i++) begin
      done_cnt = 0;
      apply(vecs[i].kind, vecs[i].d);
      exp_q.push_back({vecs[i].exp_time, vecs[i].exp_zero, vecs[i].exp_done});
      check($sformatf("vec%0d", i));
    end

    // Clear while a tick edge arrives on the last second: no done pulse
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    press(4'd1);
    enable = 1'b1; cyc(1);
    done_cnt = 0;
    clr = 1'b1; pgt_1Hz = 1'b1; cyc(1);
    clr = 1'b0; cyc(3);
    pgt_1Hz = 1'b0; cyc(2);
    exp_q.push_back({16'h0000, 1'b1, 2'd0});
    check("clr_on_tick");
    enable = 1'b0; cyc(1);

    // Reset while a key is held: releasing it must not load; a fresh press does
    press(4'd6);
    loadn = 1'b0; D = 4'd3; cyc(2);
    rst = 1'b1; cyc(2);
    loadn = 1'b1; cyc(1);
    rst = 1'b0; cyc(3);
    done_cnt = 0;
    exp_q.push_back({16'h0000, 1'b1, 2'd0});
    check("rst_held_key");
    press(4'd3);
    exp_q.push_back({16'h0003, 1'b0, 2'd0});
    check("repress_after_rst");

    // Key and tick edges together while counting: only the count takes effect
    enable = 1'b1; cyc(1);
    done_cnt = 0;
    loadn = 1'b0; D = 4'd8; pgt_1Hz = 1'b1; cyc(2);
    loadn = 1'b1; pgt_1Hz = 1'b0; cyc(2);
    exp_q.push_back({16'h0002, 1'b0, 2'd0});
    check("key_and_tick_counting");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
